// File: rtl/ua_pkg.sv
// Shared UA frame constants and FSM state encoding, common to the transmitter and receiver.
package ua_pkg;

  typedef logic [1:0] ua_state_t;

  localparam ua_state_t ST_IDLE  = 2'd0;
  localparam ua_state_t ST_START = 2'd1;
  localparam ua_state_t ST_DATA  = 2'd2;
  localparam ua_state_t ST_STOP  = 2'd3;

  localparam logic        UA_START_BIT          = 1'b0;
  localparam logic        UA_STOP_BIT           = 1'b1;
  localparam int unsigned UA_DATA_BITS          = 8;
  localparam int unsigned UA_OVERSAMPLE_DEFAULT = 16;

endpackage

// File: rtl/ua_transmitter.sv
// UART serializer: start bit, 8 data bits LSB first, STOP_BITS stop bits, with a one-deep
// holding register so consecutive frames leave with no idle gap.
module ua_transmitter
  import ua_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UA_OVERSAMPLE_DEFAULT,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] din_byte,
  input  logic       din_byte_wr,
  output logic       ser_out,
  output logic       tx_rdy,
  output logic       tx_busy
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(UA_DATA_BITS - 1);

  ua_state_t  state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       ser_q, ser_d;
  logic       rdy_q, busy_q;
  logic       bit_end, load;

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    bit_idx_d   = bit_idx_q;
    stop_cnt_d  = stop_cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ser_d       = ser_q;
    load        = 1'b0;
    bit_end     = enable && (tick_q == TICK_LAST);

    if (enable && (state_q != ST_IDLE)) begin
      tick_d = bit_end ? 4'd0 : tick_q + 4'd1;
    end

    if (enable) begin
      case (state_q)
        ST_IDLE: load = hold_full_q;
        ST_START: begin
          if (bit_end) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
            ser_d     = shift_q[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx_q == BIT_LAST) begin
              state_d    = ST_STOP;
              stop_cnt_d = 1'b0;
              ser_d      = UA_STOP_BIT;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
              ser_d     = shift_q[bit_idx_q + 3'd1];
            end
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if ((STOP_BITS == 2) && !stop_cnt_q) begin
              stop_cnt_d = 1'b1;
            end else if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d = ST_IDLE;
              ser_d   = UA_STOP_BIT;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Loading starts the frame on this same edge, so the start bit appears immediately.
    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      state_d     = ST_START;
      tick_d      = 4'd0;
      bit_idx_d   = 3'd0;
      ser_d       = UA_START_BIT;
    end

    // rdy_q is low whenever hold is full, so a write can never collide with a load.
    if (din_byte_wr && rdy_q) begin
      hold_d      = din_byte;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tick_q      <= 4'd0;
      bit_idx_q   <= 3'd0;
      stop_cnt_q  <= 1'b0;
      shift_q     <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      ser_q       <= UA_STOP_BIT;
      rdy_q       <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_idx_q   <= bit_idx_d;
      stop_cnt_q  <= stop_cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ser_q       <= ser_d;
      rdy_q       <= !hold_full_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign ser_out = ser_q;
  assign tx_rdy  = rdy_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_ua_transmitter.sv
// Bench for ua_transmitter: a tick-level frame model checked every cycle on two instances
// (1 and 2 stop bits), plus directed frames decoded by a simple bench-side receiver.
module tb_ua_transmitter;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] din = 8'h00;
  logic [1:0] wr = 2'b00;
  logic [1:0] ser, rdy, busy;

  int n_chk = 0;
  int n_err = 0;
  int en_cnt = 0;
  int en_div = 1;
  bit en_freeze = 1'b0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ua_transmitter #(.OVERSAMPLE(OS), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .din_byte(din), .din_byte_wr(wr[0]),
    .ser_out(ser[0]), .tx_rdy(rdy[0]), .tx_busy(busy[0])
  );

  ua_transmitter #(.OVERSAMPLE(OS), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .din_byte(din), .din_byte_wr(wr[1]),
    .ser_out(ser[1]), .tx_rdy(rdy[1]), .tx_busy(busy[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Oversample tick: one clk wide every en_div clocks unless frozen.
  always @(negedge clk) begin
    en_cnt = en_cnt + 1;
    enable = !en_freeze && ((en_cnt % en_div) == 0);
  end

  // Model: a frame is a list of line levels, each held OS ticks; remaining ticks index it.
  int         m_rem  [2];
  logic [11:0] m_frm [2];
  logic        m_hf  [2];
  logic [7:0]  m_hb  [2];
  logic [1:0]  m_ser, m_busy, m_rdy;
  int          t_r, t_tot;
  logic [11:0] t_f;
  logic        t_h, t_s, t_b;
  logic [7:0]  t_hb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_rem[k] <= 0;
        m_frm[k] <= '1;
        m_hf[k]  <= 1'b0;
        m_hb[k]  <= 8'h00;
      end
      m_ser  <= 2'b11;
      m_busy <= 2'b00;
      m_rdy  <= 2'b11;
    end else begin
      for (int k = 0; k < 2; k++) begin
        t_tot = (9 + k + 1) * OS;
        t_r = m_rem[k]; t_f = m_frm[k]; t_h = m_hf[k]; t_hb = m_hb[k];
        t_s = m_ser[k]; t_b = m_busy[k];
        if (enable) begin
          if (t_r == 0 && t_h) begin
            t_f = {3'b111, t_hb, 1'b0};
            t_r = t_tot;
            t_h = 1'b0;
          end
          if (t_r > 0) begin
            t_s = t_f[(t_tot - t_r) / OS];
            t_b = 1'b1;
            t_r = t_r - 1;
          end else begin
            t_s = 1'b1;
            t_b = 1'b0;
          end
        end
        if (wr[k] && !m_hf[k]) begin
          t_hb = din;
          t_h  = 1'b1;
        end
        m_rem[k]  <= t_r;
        m_frm[k]  <= t_f;
        m_hf[k]   <= t_h;
        m_hb[k]   <= t_hb;
        m_ser[k]  <= t_s;
        m_busy[k] <= t_b;
        m_rdy[k]  <= !t_h;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ser_out0", ser[0], m_ser[0]);
      chk("tx_rdy0", rdy[0], m_rdy[0]);
      chk("tx_busy0", busy[0], m_busy[0]);
      chk("ser_out1", ser[1], m_ser[1]);
      chk("tx_rdy1", rdy[1], m_rdy[1]);
      chk("tx_busy1", busy[1], m_busy[1]);
    end
  end

  task automatic write_byte(input int k, input logic [7:0] b);
    din   = b;
    wr[k] = 1'b1;
    @(negedge clk);
    wr[k] = 1'b0;
  endtask

  task automatic wait_rdy(input int k);
    int n = 0;
    while (!rdy[k] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_timeout", 32'(n >= 3000), 0);
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while (busy[k] && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n >= 5000), 0);
  endtask

  // Bench-side receiver: find the start edge, sample each bit in its middle.
  task automatic rx_frame(input int k, input int bclk, output logic [7:0] b, output int t0);
    int n = 0;
    b = 8'h00;
    while (ser[k] !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    t0 = en_cnt;
    chk("rx_timeout", 32'(n >= 5000), 0);
    repeat (bclk / 2 - 1) @(negedge clk);
    chk("rx_start", 32'(ser[k]), 0);
    for (int i = 0; i < 8; i++) begin
      repeat (bclk) @(negedge clk);
      b[i] = ser[k];
    end
    repeat (bclk) @(negedge clk);
    chk("rx_stop", 32'(ser[k]), 1);
  endtask

  logic [7:0] rb0, rb1, rb2, rb3;
  int         ts0, ts1, ts2, ts3;

  initial begin
    repeat (4) @(negedge clk);
    chk("reset_ser", 32'(ser), 32'h3);
    chk("reset_rdy", 32'(rdy), 32'h3);
    chk("reset_busy", 32'(busy), 32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);

    // Single frame 0xA5, enable every clk.
    fork
      rx_frame(0, OS, rb0, ts0);
      begin
        int n = 0;
        int m = 0;
        write_byte(0, 8'hA5);
        while (!busy[0] && n < 100) begin @(negedge clk); n++; end
        while (busy[0] && m < 1000) begin @(negedge clk); m++; end
        chk("busy_len", m, 160);
      end
    join
    chk("byte_a5", 32'(rb0), 32'hA5);
    chk("idle_ser", 32'(ser[0]), 1);
    chk("idle_busy", 32'(busy[0]), 0);

    // Back-to-back 0x55 then 0x0F: no idle gap between frames.
    fork
      begin
        write_byte(0, 8'h55);
        chk("rdy_after_wr", 32'(rdy[0]), 0);
        wait_rdy(0);
        write_byte(0, 8'h0F);
      end
      begin
        rx_frame(0, OS, rb0, ts0);
        rx_frame(0, OS, rb1, ts1);
      end
    join
    chk("byte_55", 32'(rb0), 32'h55);
    chk("byte_0f", 32'(rb1), 32'h0F);
    chk("no_gap", ts1 - ts0, 160);
    wait_idle(0);

    // Write while hold is full is dropped.
    fork
      begin
        write_byte(0, 8'h5A);
        wait_rdy(0);
        write_byte(0, 8'h81);
        chk("rdy_hold_full", 32'(rdy[0]), 0);
        write_byte(0, 8'h33);
      end
      begin
        rx_frame(0, OS, rb0, ts0);
        rx_frame(0, OS, rb1, ts1);
      end
    join
    chk("byte_5a", 32'(rb0), 32'h5A);
    chk("byte_81", 32'(rb1), 32'h81);
    repeat (300) @(negedge clk);
    chk("no_33_busy", 32'(busy[0]), 0);

    // Enable every 4th clk: 64 clk per bit.
    en_div = 4;
    repeat (8) @(negedge clk);
    fork
      rx_frame(0, 4 * OS, rb0, ts0);
      write_byte(0, 8'h96);
    join
    chk("byte_96", 32'(rb0), 32'h96);
    wait_idle(0);

    // Freeze enable mid data bit 2 of 0x4B (bit 2 = 0); line must hold.
    write_byte(0, 8'h4B);
    begin
      int n = 0;
      while (ser[0] !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
      chk("freeze_start_timeout", 32'(n >= 2000), 0);
    end
    repeat (64 * 3 + 32) @(negedge clk);
    en_freeze = 1'b1;
    repeat (100) begin
      @(negedge clk);
      chk("freeze_hold", 32'(ser[0]), 0);
    end
    en_freeze = 1'b0;
    wait_idle(0);

    // Asynchronous reset during data bit 3, then a clean frame.
    en_div = 1;
    repeat (4) @(negedge clk);
    write_byte(0, 8'hF0);
    begin
      int n = 0;
      while (ser[0] !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    end
    repeat (OS + OS * 3 + OS / 2 - 1) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ser", 32'(ser[0]), 1);
    chk("async_rst_rdy", 32'(rdy[0]), 1);
    chk("async_rst_busy", 32'(busy[0]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("post_rst_quiet", 32'(busy[0]), 0);
    fork
      rx_frame(0, OS, rb0, ts0);
      write_byte(0, 8'hC3);
    join
    chk("byte_c3", 32'(rb0), 32'hC3);
    wait_idle(0);

    // Back-to-back stream 0x00, 0xFF, 0x3C, 0x80.
    fork
      begin
        write_byte(0, 8'h00);
        wait_rdy(0); write_byte(0, 8'hFF);
        wait_rdy(0); write_byte(0, 8'h3C);
        wait_rdy(0); write_byte(0, 8'h80);
      end
      begin
        rx_frame(0, OS, rb0, ts0);
        rx_frame(0, OS, rb1, ts1);
        rx_frame(0, OS, rb2, ts2);
        rx_frame(0, OS, rb3, ts3);
      end
    join
    chk("lb_00", 32'(rb0), 32'h00);
    chk("lb_ff", 32'(rb1), 32'hFF);
    chk("lb_3c", 32'(rb2), 32'h3C);
    chk("lb_80", 32'(rb3), 32'h80);
    chk("lb_gap", ts3 - ts2, 160);
    wait_idle(0);

    // Two stop bits: 0x00 then 0xFF; low run is start+8 data, high run is the 2 stop bits.
    fork
      begin
        write_byte(1, 8'h00);
        wait_rdy(1);
        write_byte(1, 8'hFF);
      end
      begin
        int n = 0;
        int lo = 0;
        int hi = 0;
        while (ser[1] !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
        while (ser[1] === 1'b0 && lo < 1000) begin @(negedge clk); lo++; end
        while (ser[1] === 1'b1 && hi < 1000) begin @(negedge clk); hi++; end
        chk("sb2_low_run", lo, 9 * OS);
        chk("sb2_stop_run", hi, 2 * OS);
      end
    join
    wait_idle(1);
    chk("sb2_idle_ser", 32'(ser[1]), 1);

    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_chk, n_err);
    $fatal(1, "watchdog");
  end

endmodule
